// File: rtl/mlp_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_sequencer
//
// Layer/neuron/weight sequencer for the MLP datapath. A runtime-loadable
// layer-size table sets the network shape. After start, one MAC operand is
// issued per cycle, and each neuron's accumulator is committed in the cycle
// after its last operand. A one-cycle bubble separates layers, so that
// layer l is fully written before layer l+1 reads it.
//
// Optional feature: define MLP_BIAS_EN to append one bias operand to every
// neuron (bias_sel=1). Without it, bias_sel is tied to 0.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   cfg_we/cfg_layer/    layer-size table write (IDLE only)
//     cfg_count
//   start                begin an inference pass
//   stall                memory not ready; freezes all sequencing
//   busy, done, cfg_err  handshake / status
//   mac_valid, mac_clear operand strobe, first operand of a neuron
//   bias_sel             operand is the bias term
//   in_neuron_addr       {layer l-1, weight index}
//   weight_addr          linear weight index, restarts at 0 each pass
//   write_neuron         commit accumulator to out_neuron_addr
//   out_neuron_addr      {layer l, neuron index}
//   relu_en              apply ReLU on this write (0 on final layer)
// ---------------------------------------------------------------------------
//  state  | meaning
//  IDLE   | waiting for start; table writes accepted
//  RUN    | issuing operands, bubbles and the final write
//  DONE   | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module mlp_sequencer #(
    parameter int  LAYERS  = 4,
    parameter int  NW      = 8,
    parameter int  NADDR_W = 12,
    parameter int  WADDR_W = 16,
    localparam int LW      = ($clog2(LAYERS) < 1) ? 1 : $clog2(LAYERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [LW-1:0]      cfg_layer,
    input  logic [NW-1:0]      cfg_count,
    input  logic               start,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               mac_valid,
    output logic               mac_clear,
    output logic               bias_sel,
    output logic [NADDR_W-1:0] in_neuron_addr,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               write_neuron,
    output logic [NADDR_W-1:0] out_neuron_addr,
    output logic               relu_en
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NW-1:0]      n_tab [LAYERS];
    logic [LW-1:0]      layer;
    logic [LW-1:0]      layer_prev;
    logic [NW-1:0]      neuron;
    logic [NW-1:0]      widx;
    logic [WADDR_W-1:0] waddr;
    logic               bubble;     // inter-layer bubble cycle
    logic               tail;       // final write cycle, no operand
    logic               bias_ph;    // current operand is the bias term
    logic               wr_pend;
    logic [NADDR_W-1:0] wr_addr;
    logic               wr_relu;
    logic               err_q;

    logic tab_zero, accept, reject, op_cycle;
    logic last_w, last_n, last_l, last_op;

    always_comb begin
        tab_zero = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
            if (n_tab[i] == '0) tab_zero = 1'b1;
        end
    end

    assign layer_prev = layer - LW'(1);
    assign last_w     = (widx == n_tab[layer_prev] - NW'(1));
    assign last_n     = (neuron == n_tab[layer] - NW'(1));
    assign last_l     = (layer == LW'(LAYERS - 1));
`ifdef MLP_BIAS_EN
    assign last_op    = bias_ph;
`else
    assign last_op    = last_w;
`endif

    // A start that coincides with a table write is dropped; the write wins.
    assign accept   = (state == S_IDLE) && start && !cfg_we && !tab_zero;
    assign reject   = (state == S_IDLE) && start && !cfg_we &&  tab_zero;
    assign op_cycle = (state == S_RUN) && !bubble && !tail && !stall;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        mac_valid       = 1'b0;
        mac_clear       = 1'b0;
        bias_sel        = 1'b0;
        write_neuron    = 1'b0;
        in_neuron_addr  = '0;
        weight_addr     = '0;
        cfg_err         = err_q;
        out_neuron_addr = wr_addr;
        relu_en         = wr_relu;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy         = 1'b1;
                mac_valid    = op_cycle;
                mac_clear    = op_cycle && (widx == '0) && !bias_ph;
`ifdef MLP_BIAS_EN
                bias_sel     = op_cycle && bias_ph;
`endif
                write_neuron = wr_pend && !stall;
                if (op_cycle) begin
                    in_neuron_addr = NADDR_W'({layer_prev, widx});
                    weight_addr    = waddr;
                end
                if (tail && !stall) state_nxt = S_DONE;
            end
            S_DONE: begin
                // A stall here holds the pulse back until memory is ready.
                done = !stall;
                if (!stall) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAYERS; i++) n_tab[i] <= '0;
            layer   <= '0;
            neuron  <= '0;
            widx    <= '0;
            waddr   <= '0;
            bubble  <= 1'b0;
            tail    <= 1'b0;
            bias_ph <= 1'b0;
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_relu <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            if ((state == S_IDLE) && cfg_we && (int'(cfg_layer) < LAYERS))
                n_tab[cfg_layer] <= cfg_count;

            if (accept) begin
                layer   <= LW'(1);
                neuron  <= '0;
                widx    <= '0;
                waddr   <= '0;
                bubble  <= 1'b0;
                tail    <= 1'b0;
                bias_ph <= 1'b0;
                wr_pend <= 1'b0;
            end else if ((state == S_RUN) && !stall) begin
                wr_pend <= 1'b0;
                if (bubble) begin
                    bubble <= 1'b0;
                end else if (tail) begin
                    tail <= 1'b0;
                end else begin
                    waddr <= waddr + WADDR_W'(1);
                    if (last_op) begin
                        wr_pend <= 1'b1;
                        wr_addr <= NADDR_W'({layer, neuron});
                        wr_relu <= !last_l;
                        widx    <= '0;
                        bias_ph <= 1'b0;
                        if (!last_n) begin
                            neuron <= neuron + NW'(1);
                        end else begin
                            neuron <= '0;
                            if (last_l) tail <= 1'b1;
                            else begin
                                layer  <= layer + LW'(1);
                                bubble <= 1'b1;
                            end
                        end
                    end
`ifdef MLP_BIAS_EN
                    else if (last_w) begin
                        bias_ph <= 1'b1;
                    end
`endif
                    else begin
                        widx <= widx + NW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_sequencer.sv
module tb_mlp_sequencer;

    localparam int LAYERS  = 4;
    localparam int NW      = 8;
    localparam int NADDR_W = 12;
    localparam int WADDR_W = 16;
    localparam int LW      = 2;
    localparam int NREC    = 40;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [LW-1:0]      cfg_layer;
    logic [NW-1:0]      cfg_count;
    logic               start;
    logic               stall;
    logic               busy, done, cfg_err, mac_valid, mac_clear, bias_sel;
    logic [NADDR_W-1:0] in_neuron_addr, out_neuron_addr;
    logic [WADDR_W-1:0] weight_addr;
    logic               write_neuron, relu_en;

    mlp_sequencer #(
        .LAYERS(LAYERS), .NW(NW), .NADDR_W(NADDR_W), .WADDR_W(WADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_count(cfg_count), .start(start), .stall(stall), .busy(busy),
        .done(done), .cfg_err(cfg_err), .mac_valid(mac_valid),
        .mac_clear(mac_clear), .bias_sel(bias_sel),
        .in_neuron_addr(in_neuron_addr), .weight_addr(weight_addr),
        .write_neuron(write_neuron), .out_neuron_addr(out_neuron_addr),
        .relu_en(relu_en)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic               rv [NREC], rw [NREC], rd [NREC], rb [NREC];
    logic               rc [NREC], rs [NREC], re [NREC], rl [NREC];
    logic [NADDR_W-1:0] ri [NREC], ro [NREC];
    logic [WADDR_W-1:0] ra [NREC];

    int exp_in [$];
    int exp_out [$];
    int exp_relu [$];

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // Inputs are already driven for cycle c; sample mid-cycle, then advance.
    task automatic step(input int c);
        @(negedge clk);
        rv[c] = mac_valid;    rw[c] = write_neuron; rd[c] = done;
        rb[c] = busy;         rc[c] = mac_clear;    rs[c] = bias_sel;
        re[c] = cfg_err;      rl[c] = relu_en;      ri[c] = in_neuron_addr;
        ro[c] = out_neuron_addr;                    ra[c] = weight_addr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Start at cycle 0; a second start while busy, a table write while busy
    // and a start in the done cycle must all leave sequencing untouched.
    task automatic run_pass(input int ncyc, input int slo, input int shi,
                            input int dcyc);
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (c == 3) || (c == dcyc);
            stall     = (c >= slo) && (c <= shi);
            cfg_we    = (c == 4);
            cfg_layer = 2'd1;
            cfg_count = 8'd7;
            step(c);
        end
        start  = 1'b0;
        stall  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic check_pass(input string tag, input int ncyc,
                              input logic [31:0] ev, input logic [31:0] ew,
                              input logic [31:0] ed, input logic [31:0] eb,
                              input logic [31:0] ec, input logic [31:0] es);
        int op;
        int wr;
        op = 0;
        wr = 0;
        for (int c = 0; c < ncyc; c++) begin
            chk({tag, ".mac_valid"}, c, rv[c], ev[c]);
            chk({tag, ".write"},     c, rw[c], ew[c]);
            chk({tag, ".done"},      c, rd[c], ed[c]);
            chk({tag, ".busy"},      c, rb[c], eb[c]);
            chk({tag, ".mac_clear"}, c, rc[c], ec[c]);
            chk({tag, ".bias_sel"},  c, rs[c], es[c]);
            chk({tag, ".cfg_err"},   c, re[c], 0);
            if (ev[c]) begin
                if (op < exp_in.size()) begin
                    chk({tag, ".in_addr"}, c, ri[c], exp_in[op]);
                    chk({tag, ".w_addr"},  c, ra[c], op);
                end
                op++;
            end
            if (ew[c]) begin
                if (wr < exp_out.size()) begin
                    chk({tag, ".out_addr"}, c, ro[c], exp_out[wr]);
                    chk({tag, ".relu_en"},  c, rl[c], exp_relu[wr]);
                end
                wr++;
            end
        end
    endtask

    initial begin
        int sizes [4];
        logic [31:0] ev, ew, ed, eb, ec, es;
        sizes = '{4, 2, 2, 1};

        for (int l = 1; l < 4; l++) begin
            for (int n = 0; n < sizes[l]; n++) begin
                for (int w = 0; w < sizes[l-1]; w++) exp_in.push_back(((l - 1) << 8) | w);
`ifdef MLP_BIAS_EN
                exp_in.push_back(((l - 1) << 8) | (sizes[l-1] - 1));
`endif
                exp_out.push_back((l << 8) | n);
                exp_relu.push_back((l != 3) ? 1 : 0);
            end
        end

        rst = 1'b1; cfg_we = 1'b0; cfg_layer = '0; cfg_count = '0;
        start = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 0, busy, 0);
        chk("rst.done", 0, done, 0);
        chk("rst.cfg_err", 0, cfg_err, 0);
        chk("rst.mac_valid", 0, mac_valid, 0);
        chk("rst.write", 0, write_neuron, 0);
        chk("rst.w_addr", 0, weight_addr, 0);
        chk("rst.out_addr", 0, out_neuron_addr, 0);
        chk("rst.relu_en", 0, relu_en, 0);
        rst = 1'b0;

        // Empty table: start is rejected.
        for (int c = 0; c < 3; c++) begin
            start = (c == 0);
            step(c);
        end
        start = 1'b0;
        chk("empty.cfg_err", 1, re[1], 1);
        chk("empty.cfg_err_end", 2, re[2], 0);
        chk("empty.busy1", 1, rb[1], 0);
        chk("empty.busy2", 2, rb[2], 0);

        // Load 4-2-2-1; last entry written together with start.
        for (int c = 0; c < 6; c++) begin
            cfg_we    = (c < 4);
            cfg_layer = LW'(c);
            cfg_count = NW'(sizes[c % 4]);
            start     = (c == 3);
            step(c);
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        chk("cfgstart.busy", 4, rb[4], 0);
        chk("cfgstart.cfg_err", 4, re[4], 0);
        chk("cfgstart.valid", 4, rv[4], 0);

`ifdef MLP_BIAS_EN
        ev = rng(1,10) | rng(12,17) | rng(19,21);
        ew = rng(6,6) | rng(11,11) | rng(15,15) | rng(18,18) | rng(22,22);
        ed = rng(23,23); eb = rng(1,22);
        ec = rng(1,1) | rng(6,6) | rng(12,12) | rng(15,15) | rng(19,19);
        es = rng(5,5) | rng(10,10) | rng(14,14) | rng(17,17) | rng(21,21);
        run_pass(26, 99, 99, 23);
        check_pass("pass", 26, ev, ew, ed, eb, ec, es);

        ev = rng(1,5) | rng(8,12) | rng(14,19) | rng(21,23);
        ew = rng(8,8) | rng(13,13) | rng(17,17) | rng(20,20) | rng(24,24);
        ed = rng(25,25); eb = rng(1,24);
        ec = rng(1,1) | rng(8,8) | rng(14,14) | rng(17,17) | rng(21,21);
        es = rng(5,5) | rng(12,12) | rng(16,16) | rng(19,19) | rng(23,23);
        run_pass(28, 6, 7, 25);
        check_pass("stall", 28, ev, ew, ed, eb, ec, es);
`else
        ev = rng(1,8) | rng(10,13) | rng(15,16);
        ew = rng(5,5) | rng(9,9) | rng(12,12) | rng(14,14) | rng(17,17);
        ed = rng(18,18); eb = rng(1,17);
        ec = rng(1,1) | rng(5,5) | rng(10,10) | rng(12,12) | rng(15,15);
        es = '0;
        run_pass(21, 99, 99, 18);
        check_pass("pass", 21, ev, ew, ed, eb, ec, es);

        ev = rng(1,5) | rng(8,10) | rng(12,15) | rng(17,18);
        ew = rng(5,5) | rng(11,11) | rng(14,14) | rng(16,16) | rng(19,19);
        ed = rng(20,20); eb = rng(1,19);
        ec = rng(1,1) | rng(5,5) | rng(12,12) | rng(14,14) | rng(17,17);
        es = '0;
        run_pass(23, 6, 7, 20);
        check_pass("stall", 23, ev, ew, ed, eb, ec, es);
`endif

        // Reset mid-pass, then a start against the cleared table.
        for (int c = 0; c < 14; c++) begin
            start = (c == 0) || (c == 11);
            rst   = (c == 10);
            step(c);
        end
        start = 1'b0;
        rst   = 1'b0;
        chk("midrst.busy_before", 10, rb[10], 1);
        chk("midrst.busy", 11, rb[11], 0);
        chk("midrst.valid", 11, rv[11], 0);
        chk("midrst.clear", 11, rc[11], 0);
        chk("midrst.write", 11, rw[11], 0);
        chk("midrst.done", 11, rd[11], 0);
        chk("midrst.w_addr", 11, ra[11], 0);
        chk("midrst.in_addr", 11, ri[11], 0);
        chk("midrst.out_addr", 11, ro[11], 0);
        chk("midrst.relu_en", 11, rl[11], 0);
        chk("midrst.cfg_err0", 11, re[11], 0);
        chk("midrst.cfg_err", 12, re[12], 1);
        chk("midrst.busy_after", 12, rb[12], 0);
        chk("midrst.cfg_err_end", 13, re[13], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
